// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing one register-file write port among
//            NREQ writeback requesters. Issues one registered write per
//            accepted request, stalls on bank back-pressure and holds off all
//            writes for SYNC_CYC cycles after reset.
// Option   : REGARB_X0_DROP_EN - when defined, granted requests addressed to
//            register 0 are consumed without loading the output stage.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int SYNC_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    input  logic                 wr_ready,
    output logic                 idle
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            idle_q, idle_d;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic            w_accept;
    logic            w_drop;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // (base + offs) mod NREQ, valid for offs < NREQ
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    // Winner: first asserted request found searching upward from the pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[wrap_add(ptr_q, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(ptr_q, k);
            end
        end
    end

    // Winner's payload and acceptance qualification (reset blocks any grant)
    always_comb begin
        w_sel_addr = req_addr[int'(w_win)*AW +: AW];
        w_sel_data = req_data[int'(w_win)*DW +: DW];
        w_accept   = !rst && (state_q != S_WAIT) && (!wr_en_q || wr_ready) && w_found;
`ifdef REGARB_X0_DROP_EN
        w_drop     = (w_sel_addr == '0);
`else
        w_drop     = 1'b0;
`endif
    end

    // Next-state, grant and output-stage update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        gnt       = '0;
        idle_d    = (state_q == S_IDLE) && !wr_en_q && (req == '0);

        case (state_q)
            S_WAIT: begin
                // Hold-off lasts exactly SYNC_CYC cycles
                if (cnt_q == 4'(SYNC_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (w_accept) begin
                    gnt[w_win] = 1'b1;
                    ptr_d      = wrap_add(w_win, 1);
                    if (w_drop) begin
                        // Register-0 write swallowed; any previous write retires here
                        wr_en_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = w_sel_addr;
                        wr_data_d = w_sel_data;
                        state_d   = S_BUSY;
                    end
                end else if (wr_en_q && wr_ready) begin
                    wr_en_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            idle_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            idle_q    <= idle_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign idle    = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter: directed scenarios
//            with literal expectations, then randomized traffic compared every
//            cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int SYNC_CYC = 2;

`ifdef REGARB_X0_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               wr_ready;
    logic               idle;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .SYNC_CYC(SYNC_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .idle(idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: hold-off countdown, pointer, one-entry output stage
    // ------------------------------------------------------------------
    bit              m_known = 1'b0;
    int              m_wait  = 0;
    int              m_ptr   = 0;
    bit              m_valid = 1'b0;
    logic [AW-1:0]   m_addr  = '0;
    logic [DW-1:0]   m_data  = '0;
    bit              m_idle  = 1'b0;
    logic [NREQ-1:0] last_gnt = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int  w;
        bit  acc;
        bit  fnd;
        eg  = '0;
        w   = 0;
        acc = 1'b0;
        fnd = 1'b0;
        if (!rst && m_wait == 0 && (!m_valid || wr_ready) && req != '0) begin
            acc = 1'b1;
            for (int k = 0; k < NREQ; k++) begin
                if (!fnd && req[(m_ptr + k) % NREQ]) begin
                    fnd = 1'b1;
                    w   = (m_ptr + k) % NREQ;
                end
            end
            eg[w] = 1'b1;
        end
        last_gnt = gnt;
        if (m_known) begin
            chk("model_gnt", gnt, eg);
            chk("model_wr_en", wr_en, m_valid);
            chk("model_wr_addr", wr_addr, m_addr);
            chk("model_wr_data", wr_data, m_data);
            chk("model_idle", idle, m_idle);
        end
        if (rst) begin
            m_known = 1'b1;
            m_wait  = SYNC_CYC;
            m_ptr   = 0;
            m_valid = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_idle  = 1'b0;
        end else if (m_known) begin
            m_idle = (m_wait == 0) && !m_valid && (req == '0);
            if (m_wait > 0) begin
                m_wait--;
            end else if (acc) begin
                m_ptr = (w + 1) % NREQ;
                if (DROP && req_addr[w*AW +: AW] == '0) begin
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_addr  = req_addr[w*AW +: AW];
                    m_data  = req_data[w*DW +: DW];
                end
            end else if (m_valid && wr_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic new_req(input int i);
        req[i] = 1'b1;
        set_req(i, ($urandom % 4 == 0) ? AW'(0) : AW'($urandom), $urandom);
    endtask

    logic [NREQ-1:0] rr_g [5];
    logic [AW-1:0]   rr_a [5];

    initial begin
        rst = 1'b1; req = '0; req_addr = '0; req_data = '0; wr_ready = 1'b1;

        // Reset values
        step();
        neg();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_idle", idle, 0);
        chk("rst_gnt", gnt, 0);
        step();

        // Hold-off: gnt blocked for SYNC_CYC cycles after release
        rst = 1'b0; req = 3'b001; set_req(0, 5'd5, 32'h1111_0000);
        neg(); chk("hold_gnt_c0", gnt, 3'b000); step();
        neg(); chk("hold_gnt_c1", gnt, 3'b000); step();
        neg(); chk("hold_gnt_c2", gnt, 3'b001); step();
        req = '0;
        neg(); chk("hold_wr_en_c3", wr_en, 1); chk("hold_addr_c3", wr_addr, 5); step();
        neg(); chk("hold_wr_en_c4", wr_en, 0); step();

        // Round-robin from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        set_req(0, 5'd5, 32'h0000_0005);
        set_req(1, 5'd6, 32'h0000_0006);
        set_req(2, 5'd7, 32'h0000_0007);
        req = 3'b111;
        step(); step();
        rr_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
        rr_a = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd5};
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("rr_gnt", gnt, rr_g[i]);
            if (i > 0) chk("rr_wr_addr", wr_addr, rr_a[i]);
            step();
            if (i == 3) req = '0;
        end
        neg(); chk("rr_drain", wr_en, 0);

        // Back-pressure on the addr-9 write (pointer now 1)
        req = 3'b010; set_req(1, 5'd9, 32'hDEAD_BEEF);
        neg(); chk("bp_gnt", gnt, 3'b010); step();
        req = 3'b001; set_req(0, 5'd4, 32'h0000_4444); wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("bp_wr_en", wr_en, 1);
            chk("bp_wr_addr", wr_addr, 9);
            chk("bp_wr_data", wr_data, 32'hDEAD_BEEF);
            chk("bp_gnt_hold", gnt, 0);
            step();
        end
        wr_ready = 1'b1;
        neg(); chk("bp_gnt_resume", gnt, 3'b001); chk("bp_addr_last", wr_addr, 9); step();
        req = '0;
        neg(); chk("bp_next_addr", wr_addr, 4); step();

        // Pointer hold / wrap (pointer is 1)
        req = 3'b100; set_req(2, 5'd12, 32'h0000_00CC);
        neg(); chk("ptr_gnt_2", gnt, 3'b100); step();
        req = 3'b011;
        neg(); chk("ptr_gnt_0", gnt, 3'b001); step();
        req = '0;

        // Mid-operation reset while stalled
        req = 3'b010;
        neg(); chk("mr_gnt", gnt, 3'b010); step();
        req = '0; wr_ready = 1'b0;
        neg(); chk("mr_stalled", wr_en, 1); step();
        rst = 1'b1; step();
        rst = 1'b0; wr_ready = 1'b1; req = 3'b111;
        neg(); chk("mr_wr_en", wr_en, 0); chk("mr_gnt_c0", gnt, 0); step();
        neg(); chk("mr_gnt_c1", gnt, 0); step();
        neg(); chk("mr_gnt_c2", gnt, 3'b001); step();
        req = '0;

        // Address-0 requests (pointer is 1, previous write still in stage)
        req = 3'b001; set_req(0, 5'd0, 32'h0000_A0A0);
        neg(); chk("x0_gnt0", gnt, 3'b001); step();
        req = 3'b010; set_req(1, 5'd3, 32'h0000_3333);
        neg();
        chk("x0_gnt1", gnt, 3'b010);
        chk("x0_first_wr_en", wr_en, DROP ? 1'b0 : 1'b1);
        if (!DROP) chk("x0_first_addr", wr_addr, 0);
        step();
        req = '0;
        neg(); chk("x0_second_wr_en", wr_en, 1); chk("x0_second_addr", wr_addr, 3);
        chk("x0_second_data", wr_data, 32'h0000_3333); step();
        neg(); chk("x0_drain", wr_en, 0); step();
        neg(); chk("idle_high", idle, 1); step();

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom % 300 == 0);
            wr_ready = ($urandom % 4 != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && last_gnt[i]) begin
                    if ($urandom % 2 == 0) new_req(i);
                    else req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom % 16 == 0) req[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    new_req(i);
                end
            end
            step();
        end

        rst = 1'b0;
        neg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single register-file write port among NREQ writeback requesters (e.g. ALU, load unit, CSR unit) using round-robin arbitration.
- Drives one registered write (enable/address/data) per accepted request and stalls on back-pressure from the register bank.
- After reset, holds off all writes for SYNC_CYC cycles so the bank's internal reset synchronisers have released before the first write.

## Interface
- NREQ, 3, number of requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width
- SYNC_CYC, 2, post-reset hold-off cycles (1..15)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request i valid; held with addr/data stable until granted
- req_addr  in  NREQ*AW  requester i address at [i*AW +: AW]
- req_data  in  NREQ*DW  requester i data at [i*DW +: DW]
- gnt  out  NREQ  one-hot accept, combinational, same cycle as acceptance
- wr_en  out  1  registered write valid to register bank
- wr_addr  out  AW  registered write address
- wr_data  out  DW  registered write data
- wr_ready  in  1  bank accepts the offered write at this edge
- idle  out  1  registered; high in IDLE with wr_en=0 and req=0

## Operation
- States:
  - WAIT: entered on rst. Counts SYNC_CYC cycles, then goes to IDLE. gnt=0 throughout.
  - IDLE: output stage empty.
  - BUSY: wr_en=1.
- Accept condition: state != WAIT, (wr_en==0 or wr_ready==1), and |req.
- Winner selection: first set req bit searching upward from ptr, modulo NREQ. gnt has exactly that bit set; all other bits are 0.
- On accept:
  - wr_en<=1.
  - wr_addr/wr_data<=the winner's fields.
  - ptr<=(winner+1) mod NREQ.
  - Next state is BUSY.
- wr_en=1 and wr_ready=1 with no accept: wr_en<=0 and next state is IDLE.
- wr_en=1 and wr_ready=0: wr_en/wr_addr/wr_data are held, gnt=0, state stays BUSY.
- ptr advances only on accept; it is unaffected by requests that are not granted.
- A requester may drop req before being granted. Nothing is recorded for it.
- Bank consumes write X and a new request is accepted in the same cycle: X retires at that edge and the new write is loaded, so wr_en stays high with no gap.

## Timing
- Reset values:
  - gnt=0, wr_en=0, wr_addr=0, wr_data=0, idle=0.
  - ptr=0, state=WAIT, counter=0.
- rst asserted mid-operation:
  - Any pending write is discarded; wr_en=0 the cycle after the reset edge.
  - Hold-off restarts.
- First possible gnt: cycle SYNC_CYC after the first clock edge with rst=0.
- Latency: gnt in cycle N, then wr_en=1 visible from cycle N+1.
- Throughput: one write per cycle while wr_ready=1.
- Fairness: a continuously requesting requester is granted within NREQ accepts.
- idle goes high one cycle after its conditions are met.

## Configuration
- REGARB_X0_DROP_EN defined:
  - A granted request with address 0 is consumed. gnt pulses and ptr advances.
  - The output stage is not loaded: wr_en is not set by this grant, and its data is discarded.
  - Accept still requires (wr_en==0 or wr_ready==1).
- Undefined: address-0 requests are forwarded like any other.

## Test plan
- Reset hold-off: req=3'b001 held from reset release, SYNC_CYC=2.
  - gnt=0 for 2 cycles; gnt=3'b001 on cycle 2; wr_en=1 on cycle 3.
- Round-robin: req=3'b111 held, wr_ready=1.
  - gnt sequence 001,010,100,001.
  - wr_addr follows the requesters' addresses (5,6,7,5) one cycle later.
- Back-pressure: wr_ready=0 for 3 cycles after the write to addr 9, data 32'hDEAD_BEEF.
  - wr_en/wr_addr/wr_data held for those 3 cycles, gnt=0.
  - Next gnt in the cycle wr_ready returns to 1.
- Pointer hold: req=3'b100 only, after ptr=1.
  - gnt=3'b100, then ptr=0.
  - Next req=3'b011 is granted to requester 0.
- Mid-operation reset: rst pulsed while wr_en=1 and wr_ready=0.
  - wr_en=0 after the edge; no gnt for SYNC_CYC cycles.
- X0 drop: req0 with addr 0, then req1 with addr 3, wr_ready=1.
  - With REGARB_X0_DROP_EN: gnt 001 then 010; only the addr 3 write appears on wr_en.
  - Without the macro: both writes appear, addr 0 first.
